// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer: selects the next PC from sequential step,
// redirect or stall hold, and stops the core on halt, out-of-range or misaligned redirect.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 64,
  parameter logic [31:0] HALT_WORD  = 32'h0000_0073
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fetch_count
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN:0] PC_LIMIT = (XLEN+1)'(IMEM_WORDS) * (XLEN+1)'(4);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] count_next;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] redirect_pc;
  logic            accept;
  logic            halt_word;
  logic            misaligned;
  logic            out_of_range;

  // Decode of the current cycle's fetch and redirect request
  assign accept       = (state == RUN) && !stall;
  assign halt_word    = (instruction == HALT_WORD) || (instruction == '0);
  assign misaligned   = branch_taken && (branch_target[1:0] != 2'b00);
  assign seq_pc       = pc + XLEN'(4);
  assign redirect_pc  = branch_taken ? branch_target : seq_pc;
  assign out_of_range = {1'b0, redirect_pc} >= PC_LIMIT;
  assign pc_plus4     = seq_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // HALT and FAULT are terminal; only reset leaves them
  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (!stall) begin
          if (halt_word) begin
            state_next = HALT;
          end else if (misaligned) begin
            state_next = FAULT;
          end else if (out_of_range) begin
            state_next = HALT;
          end
        end
      end
      HALT:    state_next = HALT;
      FAULT:   state_next = FAULT;
      default: state_next = FAULT;
    endcase
  end

  always_comb begin
    fetch_valid = 1'b0;
    halted      = 1'b0;
    fault       = 1'b0;
    case (state)
      RUN:     fetch_valid = 1'b1;
      HALT:    halted      = 1'b1;
      FAULT:   fault       = 1'b1;
      default: fault       = 1'b1;
    endcase
  end

  // PC holds on a halt word or misaligned redirect; an out-of-range target still loads
  always_comb begin
    pc_next    = pc;
    count_next = fetch_count;
    if (accept) begin
      if (!halt_word && !misaligned) begin
        pc_next = redirect_pc;
      end
      if (fetch_count != '1) begin
        count_next = fetch_count + XLEN'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      fetch_count <= '0;
    end else begin
      pc          <= pc_next;
      fetch_count <= count_next;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a reference model pushes expected state per
// cycle, popped and compared after each rising edge; a second small-memory instance checks bounds.
module tb_pc_sequencer;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] HALT = 32'h0000_0073;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] cnt;
    logic        valid;
    logic        halted;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        halted;
  logic        fault;
  logic [31:0] fetch_count;

  logic [31:0] pc2;
  logic [31:0] pc_plus4_2;
  logic        fetch_valid2;
  logic        halted2;
  logic        fault2;
  logic [31:0] fetch_count2;

  logic [31:0] imem [64];
  exp_t        sb [$];

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  int          m_st;

  always #5 clk = ~clk;

  assign instruction = (pc < 32'd256) ? imem[pc[7:2]] : NOP;

  pc_sequencer #(.IMEM_WORDS(64)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .instruction(instruction), .pc(pc),
    .pc_plus4(pc_plus4), .fetch_valid(fetch_valid), .halted(halted),
    .fault(fault), .fetch_count(fetch_count)
  );

  pc_sequencer #(.IMEM_WORDS(4)) dut_small (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .instruction(NOP), .pc(pc2),
    .pc_plus4(pc_plus4_2), .fetch_valid(fetch_valid2), .halted(halted2),
    .fault(fault2), .fetch_count(fetch_count2)
  );

  function automatic logic [31:0] fetch_word(input logic [31:0] a);
    logic [5:0] idx;
    idx = a[7:2];
    return (a < 32'd256) ? imem[idx] : NOP;
  endfunction

  // Drive one cycle, predict the post-edge state, then compare it after the edge
  task automatic step(input logic r, input logic s, input logic b, input logic [31:0] t);
    exp_t        e;
    exp_t        got;
    logic [31:0] w;
    logic [31:0] npc;
    reset = r; stall = s; branch_taken = b; branch_target = t;
    w = fetch_word(m_pc);
    if (r) begin
      m_pc = 32'h0; m_cnt = 32'h0; m_st = 0;
    end else if (m_st == 0 && !s) begin
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      if (w == HALT || w == 32'h0) begin
        m_st = 1;
      end else if (b && t[1:0] != 2'b00) begin
        m_st = 2;
      end else begin
        npc = b ? t : m_pc + 32'd4;
        m_pc = npc;
        if (npc >= 32'd256) m_st = 1;
      end
    end
    e.pc = m_pc; e.cnt = m_cnt;
    e.valid = (m_st == 0); e.halted = (m_st == 1); e.fault = (m_st == 2);
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = {pc, fetch_count, fetch_valid, halted, fault};
    e = sb.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL step: got pc=%h cnt=%0d v=%b h=%b f=%b, expected pc=%h cnt=%0d v=%b h=%b f=%b",
               got.pc, got.cnt, got.valid, got.halted, got.fault,
               e.pc, e.cnt, e.valid, e.halted, e.fault);
    end
    checks++;
    if (pc_plus4 !== e.pc + 32'd4) begin
      errors++;
      $display("FAIL pc_plus4: got %h expected %h", pc_plus4, e.pc + 32'd4);
    end
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    checks++;
    if (pc !== 32'h0 || pc_plus4 !== 32'h4 || fetch_count !== 32'h0 || fetch_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset: got pc=%h p4=%h cnt=%0d v=%b, expected 0/4/0/1", pc, pc_plus4, fetch_count, fetch_valid);
    end
  endtask

  task automatic test_sequential();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (pc !== 32'd32 || fetch_count !== 32'd8 || fetch_valid !== 1'b1) begin
      errors++;
      $display("FAIL sequential: got pc=%0d cnt=%0d v=%b, expected 32/8/1", pc, fetch_count, fetch_valid);
    end
  endtask

  task automatic test_stall();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (pc !== 32'd8 || fetch_count !== 32'd2) begin
      errors++;
      $display("FAIL stall_hold: got pc=%0d cnt=%0d, expected 8/2", pc, fetch_count);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (pc !== 32'd12 || fetch_count !== 32'd3) begin
      errors++;
      $display("FAIL stall_resume: got pc=%0d cnt=%0d, expected 12/3", pc, fetch_count);
    end
  endtask

  task automatic test_branch();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h40);
    checks++;
    if (pc !== 32'h40 || pc_plus4 !== 32'h44 || fetch_count !== 32'd4) begin
      errors++;
      $display("FAIL branch: got pc=%h p4=%h cnt=%0d, expected 40/44/4", pc, pc_plus4, fetch_count);
    end
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h40);
    checks++;
    if (pc !== 32'd12 || fetch_count !== 32'd3) begin
      errors++;
      $display("FAIL stall_branch: got pc=%0d cnt=%0d, expected 12/3", pc, fetch_count);
    end
  endtask

  task automatic test_fault();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h42);
    checks++;
    if (fault !== 1'b1 || fetch_valid !== 1'b0 || pc !== 32'd8 || fetch_count !== 32'd3) begin
      errors++;
      $display("FAIL fault: got f=%b v=%b pc=%0d cnt=%0d, expected 1/0/8/3", fault, fetch_valid, pc, fetch_count);
    end
    step(1'b0, 1'b0, 1'b1, 32'h40);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (fault !== 1'b1 || pc !== 32'd8) begin
      errors++;
      $display("FAIL fault_sticky: got f=%b pc=%0d, expected 1/8", fault, pc);
    end
    step(1'b1, 1'b0, 1'b1, 32'h42);
    checks++;
    if (fault !== 1'b0 || pc !== 32'h0 || fetch_valid !== 1'b1) begin
      errors++;
      $display("FAIL fault_reset: got f=%b pc=%h v=%b, expected 0/0/1", fault, pc, fetch_valid);
    end
  endtask

  task automatic test_halt(input logic [31:0] word);
    imem[5] = word;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (halted !== 1'b1 || pc !== 32'd20 || fetch_count !== 32'd6 || fetch_valid !== 1'b0) begin
      errors++;
      $display("FAIL halt %h: got h=%b pc=%0d cnt=%0d v=%b, expected 1/20/6/0", word, halted, pc, fetch_count, fetch_valid);
    end
    step(1'b0, 1'b0, 1'b1, 32'h40);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (halted !== 1'b1 || pc !== 32'd20 || fetch_count !== 32'd6) begin
      errors++;
      $display("FAIL halt_frozen: got h=%b pc=%0d cnt=%0d, expected 1/20/6", halted, pc, fetch_count);
    end
    imem[5] = NOP;
  endtask

  task automatic test_back_to_back();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h80);
    step(1'b0, 1'b0, 1'b1, 32'h10);
    checks++;
    if (pc !== 32'h10 || fetch_count !== 32'd2 || halted !== 1'b0) begin
      errors++;
      $display("FAIL b2b: got pc=%h cnt=%0d h=%b, expected 10/2/0", pc, fetch_count, halted);
    end
    step(1'b0, 1'b0, 1'b1, 32'h100);
    checks++;
    if (pc !== 32'h100 || fetch_count !== 32'd3 || halted !== 1'b1) begin
      errors++;
      $display("FAIL branch_oob: got pc=%h cnt=%0d h=%b, expected 100/3/1", pc, fetch_count, halted);
    end
  endtask

  task automatic test_bounds();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (pc2 !== 32'd12 || halted2 !== 1'b0 || fetch_valid2 !== 1'b1) begin
      errors++;
      $display("FAIL bounds_pre: got pc=%0d h=%b v=%b, expected 12/0/1", pc2, halted2, fetch_valid2);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (pc2 !== 32'd16 || fetch_count2 !== 32'd4 || halted2 !== 1'b1 || fetch_valid2 !== 1'b0 || fault2 !== 1'b0) begin
      errors++;
      $display("FAIL bounds: got pc=%0d cnt=%0d h=%b v=%b f=%b, expected 16/4/1/0/0",
               pc2, fetch_count2, halted2, fetch_valid2, fault2);
    end
  endtask

  task automatic test_random();
    logic [31:0] t;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 200; i++) begin
      t = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      if ($urandom_range(0, 15) == 0) t[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 20) == 0) t = 32'h0000_0100 + {$urandom_range(0, 8), 2'b00};
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0), t);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = NOP;
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    m_pc = 32'h0; m_cnt = 32'h0; m_st = 0;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_fault();
    test_halt(HALT);
    test_halt(32'h0);
    test_back_to_back();
    test_bounds();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
